// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared encodings and constants for the AES trace stimulus path
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_GAP       = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_t;

    // Reduction term for x^128 + x^7 + x^2 + x + 1
    localparam logic [127:0] GF128_POLY = 128'h87;

    // Nominal number of busy cycles the static-key core takes per block
    localparam int AES_CORE_LATENCY = 52;

    // Cycles after load within which the core must raise busy
    localparam int WAIT_BUSY_LIMIT = 4;

endpackage

// File: rtl/aes_gf128_lfsr.sv
// rtl/aes_gf128_lfsr.sv - combinational GF(2^128) doubling used to step the block pattern
module aes_gf128_lfsr
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    // Shift left one bit and fold the carried-out top bit back in via the reduction term
    assign dout = {din[126:0], 1'b0} ^ (din[127] ? GF128_POLY : 128'd0);

endmodule

// File: rtl/aes_trace_sequencer.sv
// rtl/aes_trace_sequencer.sv - drives blocks into the AES core and frames each operation for the scope
module aes_trace_sequencer
    import aes_pkg::*;
#(
    parameter logic [127:0] SEED         = 128'h8000_0000_0000_0000_0000_0000_0000_0001,
    parameter logic [31:0]  NUM_BLOCKS   = 32'd0,
    parameter logic [15:0]  GAP_CYCLES   = 16'd32,
    parameter logic [7:0]   BUSY_TIMEOUT = 8'd255
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         chain_i,
    input  logic         dec_i,
    input  logic         core_busy_i,
    input  logic [127:0] core_data_i,
    output logic         core_load_o,
    output logic         core_dec_o,
    output logic [127:0] core_data_o,
    output logic         trigger_o,
    output logic [127:0] result_o,
    output logic         result_valid_o,
    output logic [31:0]  block_count_o,
    output logic         running_o,
    output logic         fault_o
);

    localparam logic [1:0] WAIT_BUSY_LAST = 2'(WAIT_BUSY_LIMIT - 1);

    seq_state_t   state;
    logic         chain_q;
    logic         stop_flag;
    logic [1:0]   wait_cnt;
    logic [7:0]   busy_cnt;
    logic [15:0]  gap_cnt;
    logic [127:0] lfsr_next;
    logic         run_done;

    aes_gf128_lfsr u_lfsr (
        .din  (core_data_o),
        .dout (lfsr_next)
    );

    // A run ends at a block boundary once stopped or once the programmed block count is reached
    always_comb begin
        run_done = stop_flag || stop_i ||
                   ((NUM_BLOCKS != 32'd0) && (block_count_o == NUM_BLOCKS));
    end

    // Sequencer FSM; all outputs are registered and change together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            chain_q        <= 1'b0;
            stop_flag      <= 1'b0;
            wait_cnt       <= 2'd0;
            busy_cnt       <= 8'd0;
            gap_cnt        <= 16'd0;
            core_load_o    <= 1'b0;
            core_dec_o     <= 1'b0;
            core_data_o    <= SEED;
            trigger_o      <= 1'b0;
            result_o       <= 128'd0;
            result_valid_o <= 1'b0;
            block_count_o  <= 32'd0;
            running_o      <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            core_load_o    <= 1'b0;
            result_valid_o <= 1'b0;
            if (state != ST_IDLE && stop_i) begin
                stop_flag <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_FAULT: begin
                    if (start_i) begin
                        chain_q       <= chain_i;
                        core_dec_o    <= dec_i;
                        block_count_o <= 32'd0;
                        stop_flag     <= stop_i;
                        fault_o       <= 1'b0;
                        core_load_o   <= 1'b1;
                        trigger_o     <= 1'b1;
                        running_o     <= 1'b1;
                        state         <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    wait_cnt <= 2'd0;
                    busy_cnt <= 8'd0;
                    state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (core_busy_i) begin
                        busy_cnt <= 8'd1;
                        state    <= ST_WAIT_DONE;
                    end else if (wait_cnt == WAIT_BUSY_LAST) begin
                        fault_o   <= 1'b1;
                        trigger_o <= 1'b0;
                        state     <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!core_busy_i) begin
                        state <= ST_CAPTURE;
                    end else if (busy_cnt >= BUSY_TIMEOUT) begin
                        fault_o   <= 1'b1;
                        trigger_o <= 1'b0;
                        state     <= ST_FAULT;
                    end else if (busy_cnt != 8'hFF) begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                ST_CAPTURE: begin
                    result_o       <= core_data_i;
                    result_valid_o <= 1'b1;
                    trigger_o      <= 1'b0;
                    block_count_o  <= block_count_o + 32'd1;
                    core_data_o    <= chain_q ? core_data_i : lfsr_next;
                    gap_cnt        <= 16'd0;
                    state          <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_CYCLES) begin
                        if (run_done) begin
                            running_o <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            core_load_o <= 1'b1;
                            trigger_o   <= 1'b1;
                            state       <= ST_LOAD;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_trace_sequencer.md
Name: aes_trace_sequencer

Overview:
- Upstream stimulus stage for the static-key AES core in the power-analysis build, which has no external I/O.
- Generates a deterministic stream of 128-bit input blocks and pulses the core's load.
- Tracks the core's busy flag, captures each result, and emits a scope trigger window around every operation.
- Runs a programmable number of blocks, with an idle gap between them so traces stay separated.

Parameters:
- SEED, 128'h8000_0000_0000_0000_0000_0000_0000_0001: initial block value; must be non-zero.
- NUM_BLOCKS, 32'd0: blocks per run; 0 means run until stop_i.
- GAP_CYCLES, 16'd32: idle cycles after each capture before the next load; 0 is legal.
- BUSY_TIMEOUT, 8'd255: maximum busy cycles before a fault is declared.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start_i  in  1  pulse; begins a run from IDLE; ignored elsewhere
- stop_i  in  1  pulse; ends the run after the current block completes
- chain_i  in  1  sampled at start: 1 = next block is the previous result; 0 = LFSR step
- dec_i  in  1  sampled at start; drives core_dec_o for the whole run
- core_busy_i  in  1  busy from the AES core
- core_data_i  in  128  result from the AES core
- core_load_o  out  1  one-cycle load pulse to the core
- core_dec_o  out  1  decrypt select to the core
- core_data_o  out  128  block presented to the core
- trigger_o  out  1  scope trigger
- result_o  out  128  last captured result
- result_valid_o  out  1  one-cycle pulse when result_o updates
- block_count_o  out  32  blocks completed this run
- running_o  out  1  high while not in IDLE
- fault_o  out  1  sticky; set on timeout

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; all 1-bit outputs 0.
  - core_data_o = SEED; result_o = 0; block_count_o = 0.
- FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, CAPTURE, GAP, FAULT.
- IDLE:
  - On start_i: latch chain_i and dec_i, clear block_count_o and the stop flag, go to LOAD.
  - core_data_o keeps its last value; it is reloaded to SEED only by reset.
- LOAD:
  - core_load_o = 1 for exactly one cycle; trigger_o rises this cycle.
  - Busy counter cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for core_busy_i = 1, then go to WAIT_DONE.
  - The core asserts busy on the cycle after load.
  - If busy is not seen within 4 cycles, go to FAULT.
- WAIT_DONE:
  - Count busy cycles (8-bit, saturating).
  - On core_busy_i = 0, go to CAPTURE.
  - If the count reaches BUSY_TIMEOUT, go to FAULT.
  - Nominal core latency is 52 busy cycles.
- CAPTURE:
  - result_o <= core_data_i; result_valid_o pulses; trigger_o falls.
  - block_count_o increments, wrapping at 2^32.
  - core_data_o <= chained ? core_data_i : lfsr(core_data_o).
  - lfsr(x) = {x[126:0],1'b0} ^ (x[127] ? 128'h87 : 0), i.e. GF(2^128) doubling.
  - Go to GAP.
- GAP:
  - Wait GAP_CYCLES cycles.
  - Then go to IDLE if the stop flag is set, or if NUM_BLOCKS != 0 and block_count_o == NUM_BLOCKS; otherwise go to LOAD.
  - GAP_CYCLES = 0: GAP lasts one cycle.
- stop_i:
  - Sets the stop flag in any non-IDLE state.
  - The in-flight block is never aborted; the run always finishes at a block boundary.
- FAULT:
  - fault_o = 1; trigger_o = 0; core_load_o = 0.
  - Leave only via start_i, which clears fault_o and starts a new run.
- Data hold:
  - core_data_o and core_dec_o are stable from LOAD until CAPTURE.
  - Required because the core samples its data during its init cycle, not at load.
- Simultaneous start_i and stop_i in IDLE: start wins; the stop flag is set, so exactly one block runs.
- Reset mid-run: immediate return to reset values. The core is reset on the same rst_n by the top level.

Decomposition:
- Shared aes_pkg, holding:
  - state encodings;
  - the 128'h87 reduction constant;
  - AES_CORE_LATENCY = 52;
  - WAIT_BUSY_LIMIT = 4.
- One sub-module: aes_gf128_lfsr, a combinational doubling function, reused by bench models.

Test Plan:
- Seed step: defaults, behavioural core model, start_i, chain_i = 0.
  - Result: core_data_o after the first capture = 128'h…0085; after the second = 128'h…010A.
- NUM_BLOCKS = 3, GAP_CYCLES = 32.
  - Result: exactly 3 core_load_o pulses, each 1 cycle and spaced 52 + 32 + 4 cycles apart.
  - block_count_o = 3; then IDLE with running_o = 0.
- chain_i = 1, model returning ~data.
  - Result: second block = ~SEED; third block = SEED.
  - result_valid_o pulses once per block.
- stop_i at busy cycle 20 of block 2.
  - Result: block 2 completes and is captured; no third load; block_count_o = 2.
- Model never asserts busy.
  - Result: fault_o = 1 on the 5th cycle after load; trigger_o = 0.
  - A following start_i clears fault_o and runs normally.
- rst_n pulled low during WAIT_DONE.
  - Result: all outputs go to reset values immediately, without waiting for a clock edge; core_data_o = SEED.
